idex_stage: RTL

- ID/EX pipeline register for the 5-stage MIPS datapath; captures decoded control, operands and register specifiers from decode and presents them to execute.
- Directly consumes the hazard unit's load-use stall (StallLW) and the branch/jump flush; drives the IDEX_* fields the hazard unit reads back for forwarding and stall detection.
- Inserts bubbles, holds on memory wait, and keeps saturating bubble/flush counters for performance debug.

---
 rtl/cpu_types_pkg.sv | 51 +++++
 rtl/idex_stage_if.sv | 30 +++
 rtl/idex_stage_sat_counter.sv | 24 ++
 rtl/idex_stage.sv | 62 ++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared MIPS datapath types: ALU ops, destination select and the ID/EX bundle.
package cpu_types_pkg;
   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [4:0]        regbits_t;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SUB  = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } aluop_t;

   typedef enum logic [1:0] {
      RD_RD = 2'd0,
      RD_RT = 2'd1,
      RD_RA = 2'd2
   } regdst_t;

   typedef struct packed {
      logic     valid;
      word_t    pc_plus4;
      word_t    rdat1;
      word_t    rdat2;
      word_t    imm32;
      logic [4:0] shamt;
      regbits_t rs;
      regbits_t rt;
      regbits_t rd;
      aluop_t   aluop;
      logic     alusrc;
      regdst_t  regdst;
      logic     memtoreg;
      logic     regwrite;
      logic     dREN;
      logic     dWEN;
      logic     branch;
      logic     jump;
      logic     halt;
   } idex_t;

   // All-zero encodes aluop=ALU_SLL and regdst=RD_RD, so a bubble is just zero.
   localparam idex_t IDEX_BUBBLE = '0;
endpackage

// File: rtl/idex_stage_if.sv
// Decode-to-execute bundle plus hazard-unit feedback and perf counters.
interface idex_stage_if #(parameter int CNT_W = 16);
   import cpu_types_pkg::*;

   logic             en;
   logic             stall_lw;
   logic             flush;
   idex_t            id_in;
   idex_t            ex_out;
   logic [4:0]       IDEX_rs;
   logic [4:0]       IDEX_rt;
   logic [4:0]       IDEX_rd;
   logic             IDEX_RegWrite;
   logic             IDEX_dREN;
   logic             IDEX_dWEN;
   logic [CNT_W-1:0] bubble_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport stage (
      input  en, stall_lw, flush, id_in,
      output ex_out, IDEX_rs, IDEX_rt, IDEX_rd, IDEX_RegWrite, IDEX_dREN, IDEX_dWEN,
             bubble_cnt, flush_cnt
   );

   modport tb (
      output en, stall_lw, flush, id_in,
      input  ex_out, IDEX_rs, IDEX_rt, IDEX_rd, IDEX_RegWrite, IDEX_dREN, IDEX_dWEN,
             bubble_cnt, flush_cnt
   );
endinterface

// File: rtl/idex_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (clear_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register: hold on !en, bubble on flush or load-use stall,
// otherwise capture decode. Exposes gated fields for the hazard unit.
module idex_stage
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic         CLK,
   input  logic         RST,
   idex_stage_if.stage  bus
);
   idex_t ex_q, ex_d;
   logic  flush_inc, bubble_inc;

   // Flush outranks stall; both are ignored while the pipe is held.
   always_comb begin
      ex_d = ex_q;
      if (bus.en) begin
         if (bus.flush)         ex_d = IDEX_BUBBLE;
         else if (bus.stall_lw) ex_d = IDEX_BUBBLE;
         else                   ex_d = bus.id_in;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) ex_q <= IDEX_BUBBLE;
      else     ex_q <= ex_d;
   end

   // Only a real instruction counts as squashed.
   assign flush_inc  = bus.en & bus.flush & bus.id_in.valid;
   assign bubble_inc = bus.en & ~bus.flush & bus.stall_lw;

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk_i   (CLK),
      .clear_i (RST),
      .inc_i   (bubble_inc),
      .cnt_o   (bus.bubble_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i   (CLK),
      .clear_i (RST),
      .inc_i   (flush_inc),
      .cnt_o   (bus.flush_cnt)
   );

   always_comb begin
      case (ex_q.regdst)
         RD_RT:   bus.IDEX_rd = ex_q.rt;
         RD_RA:   bus.IDEX_rd = 5'd31;
         default: bus.IDEX_rd = ex_q.rd;
      endcase
   end

   assign bus.ex_out        = ex_q;
   assign bus.IDEX_rs       = ex_q.rs;
   assign bus.IDEX_rt       = ex_q.rt;
   assign bus.IDEX_RegWrite = ex_q.regwrite & ex_q.valid;
   assign bus.IDEX_dREN     = ex_q.dREN & ex_q.valid;
   assign bus.IDEX_dWEN     = ex_q.dWEN & ex_q.valid;
endmodule
